// File: rtl/hack_data_memory_pkg.sv
// Purpose: Hack data-memory address map constants, region encoding and decode helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hack_data_memory_pkg;

    localparam int unsigned     RAM_DEPTH_DEF    = 16384;
    localparam int unsigned     SCREEN_DEPTH_DEF = 8192;
    localparam logic [15:0]     SCREEN_BASE      = 16'h4000;
    localparam logic [15:0]     SCREEN_END       = 16'h5FFF;
    localparam logic [15:0]     KBD_ADDR         = 16'h6000;

    typedef enum logic [1:0] {
        REG_RAM     = 2'd0,
        REG_SCREEN  = 2'd1,
        REG_KBD     = 2'd2,
        REG_ILLEGAL = 2'd3
    } region_e;

    // Everything below the screen is RAM; the single keyboard word follows
    // the screen and anything else is unmapped.
    function automatic region_e decode_region(
        input logic [15:0] addr,
        input logic [15:0] screen_base,
        input logic [15:0] screen_end,
        input logic [15:0] kbd_addr
    );
        region_e r;
        if (addr < screen_base)
            r = REG_RAM;
        else if (addr <= screen_end)
            r = REG_SCREEN;
        else if (addr == kbd_addr)
            r = REG_KBD;
        else
            r = REG_ILLEGAL;
        return r;
    endfunction

endpackage

// File: rtl/hack_data_memory_if.sv
// Purpose: M-bus, keyboard producer, video read and error signals of the data memory.
// Latency: n/a (wiring only).
// Backpressure: kbd_ready gates keyboard codes; other paths never stall.
interface hack_data_memory_if;

    // CPU M-bus
    logic [15:0] addressM;
    logic [15:0] outM;
    logic        loadM;
    logic [15:0] inM;
    // keyboard producer
    logic        kbd_valid;
    logic [15:0] kbd_data;
    logic        kbd_ready;
    // video read port
    logic        vid_rd_en;
    logic [12:0] vid_addr;
    logic [15:0] vid_data;
    logic        vid_valid;
    // error capture
    logic        bus_err;
    logic [15:0] err_addr;

    // CPU / keyboard controller / video controller side
    modport master (
        output addressM, outM, loadM, kbd_valid, kbd_data, vid_rd_en, vid_addr,
        input  inM, kbd_ready, vid_data, vid_valid, bus_err, err_addr
    );

    // memory side
    modport slave (
        input  addressM, outM, loadM, kbd_valid, kbd_data, vid_rd_en, vid_addr,
        output inM, kbd_ready, vid_data, vid_valid, bus_err, err_addr
    );

endinterface

// File: rtl/hack_screen_ram.sv
// Purpose: dual-port screen buffer; CPU port comb read + sync write, video port registered read.
// Latency: CPU read 0 cycles, video read 1 cycle (read-before-write vs. same-edge CPU write).
// Backpressure: none; both ports accept every cycle.
// Ports: clk_i, rst_ni (async, active-low; resets video outputs only),
//        cpu_we_i/cpu_addr_i/cpu_wdata_i/cpu_rdata_o, vid_rd_en_i/vid_addr_i/vid_data_o/vid_valid_o.
module hack_screen_ram #(
    parameter int unsigned DEPTH = 8192,
    parameter int unsigned AW    = 13
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [15:0]   cpu_wdata_i,
    output logic [15:0]   cpu_rdata_o,
    input  logic          vid_rd_en_i,
    input  logic [AW-1:0] vid_addr_i,
    output logic [15:0]   vid_data_o,
    output logic          vid_valid_o
);

    logic [15:0] mem_q [DEPTH];
    logic [15:0] vid_data_q, vid_data_d;
    logic        vid_valid_q, vid_valid_d;

    assign cpu_rdata_o = mem_q[cpu_addr_i];

    // Contents are not reset; the caller gates cpu_we_i with reset.
    always_ff @(posedge clk_i) begin
        if (cpu_we_i)
            mem_q[cpu_addr_i] <= cpu_wdata_i;
    end

    // Sampling mem_q here sees the pre-edge value, so a same-edge CPU write
    // to the same word is not visible to the video port until the next read.
    always_comb begin
        vid_valid_d = vid_rd_en_i;
        vid_data_d  = vid_data_q;
        if (vid_rd_en_i)
            vid_data_d = mem_q[vid_addr_i];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vid_data_q  <= 16'h0000;
            vid_valid_q <= 1'b0;
        end else begin
            vid_data_q  <= vid_data_d;
            vid_valid_q <= vid_valid_d;
        end
    end

    assign vid_data_o  = vid_data_q;
    assign vid_valid_o = vid_valid_q;

endmodule

// File: rtl/hack_data_memory.sv
// Purpose: Hack data memory: 16K RAM, 8K screen, keyboard register, sticky bus-error capture.
// Latency: inM combinational; writes visible next cycle; video read 1 cycle.
// Backpressure: keyboard code held by producer while kbd_ready=0; CPU and video never stall.
// Ports: CLK_CPU, reset_n (async, active-low), bus (hack_data_memory_if.slave).
module hack_data_memory
    import hack_data_memory_pkg::*;
#(
    parameter int unsigned RAM_DEPTH    = RAM_DEPTH_DEF,
    parameter logic [15:0] SCREEN_BASE  = hack_data_memory_pkg::SCREEN_BASE,
    parameter int unsigned SCREEN_DEPTH = SCREEN_DEPTH_DEF,
    parameter logic [15:0] KBD_ADDR     = hack_data_memory_pkg::KBD_ADDR
) (
    input  logic                 CLK_CPU,
    input  logic                 reset_n,
    hack_data_memory_if.slave    bus
);

    localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);
    localparam int unsigned SCR_AW = $clog2(SCREEN_DEPTH);
    localparam logic [15:0] SCR_END = SCREEN_BASE + 16'(SCREEN_DEPTH) - 16'd1;

    region_e region;
    assign region = decode_region(bus.addressM, SCREEN_BASE, SCR_END, KBD_ADDR);

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------
    logic [15:0]       ram_q [RAM_DEPTH];
    logic [RAM_AW-1:0] ram_idx;
    logic [15:0]       ram_rdata;

    assign ram_idx   = bus.addressM[RAM_AW-1:0];
    assign ram_rdata = ram_q[ram_idx];

    // Writes at an edge with reset asserted are dropped.
    always_ff @(posedge CLK_CPU) begin
        if (reset_n && bus.loadM && (region == REG_RAM))
            ram_q[ram_idx] <= bus.outM;
    end

    // ------------------------------------------------------------------
    // Screen buffer
    // ------------------------------------------------------------------
    logic              scr_we;
    logic [SCR_AW-1:0] scr_idx;
    logic [15:0]       scr_rdata;

    assign scr_we  = reset_n && bus.loadM && (region == REG_SCREEN);
    assign scr_idx = SCR_AW'(bus.addressM - SCREEN_BASE);

    hack_screen_ram #(
        .DEPTH (SCREEN_DEPTH),
        .AW    (SCR_AW)
    ) u_screen (
        .clk_i       (CLK_CPU),
        .rst_ni      (reset_n),
        .cpu_we_i    (scr_we),
        .cpu_addr_i  (scr_idx),
        .cpu_wdata_i (bus.outM),
        .cpu_rdata_o (scr_rdata),
        .vid_rd_en_i (bus.vid_rd_en),
        .vid_addr_i  (bus.vid_addr),
        .vid_data_o  (bus.vid_data),
        .vid_valid_o (bus.vid_valid)
    );

    // ------------------------------------------------------------------
    // Keyboard register and handshake
    // ------------------------------------------------------------------
    logic [15:0] kbd_reg_q, kbd_reg_d;
    logic        kbd_consumed_q, kbd_consumed_d;
    logic        kbd_ready;
    logic        kbd_accept;
    logic        kbd_cpu_rd;

    // A zero code (key released) never blocks the producer.
    assign kbd_ready  = kbd_consumed_q | (kbd_reg_q == 16'h0000);
    assign kbd_accept = bus.kbd_valid & kbd_ready;
    assign kbd_cpu_rd = (region == REG_KBD) & ~bus.loadM;

    // Acceptance takes priority over a same-edge CPU read so a fresh code
    // is never marked consumed before the CPU has seen it.
    always_comb begin
        kbd_reg_d      = kbd_reg_q;
        kbd_consumed_d = kbd_consumed_q;
        if (kbd_accept) begin
            kbd_reg_d      = bus.kbd_data;
            kbd_consumed_d = (bus.kbd_data == 16'h0000);
        end else if (kbd_cpu_rd) begin
            kbd_consumed_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sticky bus-error capture (keeps the first offending address)
    // ------------------------------------------------------------------
    logic        bus_err_q, bus_err_d;
    logic [15:0] err_addr_q, err_addr_d;
    logic        bad_wr;

    assign bad_wr = bus.loadM & ((region == REG_KBD) | (region == REG_ILLEGAL));

    always_comb begin
        bus_err_d  = bus_err_q;
        err_addr_d = err_addr_q;
        if (bad_wr && !bus_err_q) begin
            bus_err_d  = 1'b1;
            err_addr_d = bus.addressM;
        end
    end

    always_ff @(posedge CLK_CPU or negedge reset_n) begin
        if (!reset_n) begin
            kbd_reg_q      <= 16'h0000;
            kbd_consumed_q <= 1'b1;
            bus_err_q      <= 1'b0;
            err_addr_q     <= 16'h0000;
        end else begin
            kbd_reg_q      <= kbd_reg_d;
            kbd_consumed_q <= kbd_consumed_d;
            bus_err_q      <= bus_err_d;
            err_addr_q     <= err_addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and outputs
    // ------------------------------------------------------------------
    logic [15:0] in_m;

    always_comb begin
        in_m = 16'h0000;
        case (region)
            REG_RAM:     in_m = ram_rdata;
            REG_SCREEN:  in_m = scr_rdata;
            REG_KBD:     in_m = kbd_reg_q;
            default:     in_m = 16'h0000;
        endcase
    end

    assign bus.inM       = in_m;
    assign bus.kbd_ready = kbd_ready;
    assign bus.bus_err   = bus_err_q;
    assign bus.err_addr  = err_addr_q;

endmodule
